// File: rtl/i2c_target_burst.sv
// I2C target with register pointer, multi-byte word bursts, pointer auto-increment and repeated START.
// Optional SCL-low bus-hang recovery is built when I2C_TARGET_TIMEOUT_EN is defined.
module i2c_target_burst #(
   parameter int unsigned DATA_BYTES  = 2,
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    SCL,
   input  logic                    SDA_OUT,
   input  logic                    SDA_OE,
   input  logic [6:0]              I2C_ADDR,
   input  logic [8*DATA_BYTES-1:0] RD_DATA,
   output logic                    SDA_IN,
   output logic [REG_AW-1:0]       reg_addr,
   output logic                    WR_STB,
   output logic [8*DATA_BYTES-1:0] WR_DATA,
   output logic                    BUSY
);
   localparam int unsigned DW  = 8 * DATA_BYTES;
   localparam int unsigned BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(DATA_BYTES - 1);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   state_t         state;
   logic           bus_sda;
   logic           scl_s1, scl_s2, scl_d;
   logic           sda_s1, sda_s2, sda_d;
   logic           scl_rise, scl_fall, start_det, stop_det;
   logic [3:0]     bit_cnt;
   logic [BCW-1:0] byte_cnt;
   logic [7:0]     sh;
   logic [DW-1:0]  word;
   logic [DW-1:0]  tx;
   logic           rnw;
   logic           ack_bit;
   logic           to_hit;

   assign bus_sda = SDA_OE ? SDA_OUT : 1'b1;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         {scl_s1, scl_s2, scl_d} <= '1;
         {sda_s1, sda_s2, sda_d} <= '1;
      end else begin
         scl_s1 <= SCL;     scl_s2 <= scl_s1;  scl_d <= scl_s2;
         sda_s1 <= bus_sda; sda_s2 <= sda_s1;  sda_d <= sda_s2;
      end
   end

   assign scl_rise  =  scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 &  scl_d;
   assign start_det =  scl_s2 &  scl_d & sda_d & ~sda_s2;
   assign stop_det  =  scl_s2 &  scl_d & ~sda_d & sda_s2;

`ifdef I2C_TARGET_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_cnt;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                to_cnt <= '0;
      else if (BUSY && !scl_s2)  to_cnt <= to_hit ? '0 : to_cnt + 1'b1;
      else                       to_cnt <= '0;
   end

   assign to_hit = BUSY && !scl_s2 && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= IDLE;
         SDA_IN   <= 1'b1;
         reg_addr <= '0;
         WR_STB   <= 1'b0;
         WR_DATA  <= '0;
         BUSY     <= 1'b0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         sh       <= '0;
         word     <= '0;
         tx       <= '0;
         rnw      <= 1'b0;
         ack_bit  <= 1'b1;
      end else begin
         WR_STB <= 1'b0;
         if (WR_STB) reg_addr <= reg_addr + 1'b1;

         if (to_hit) begin
            state  <= IDLE;
            SDA_IN <= 1'b1;
            BUSY   <= 1'b0;
         end else if (start_det) begin
            state   <= ADDR;
            bit_cnt <= '0;
            SDA_IN  <= 1'b1;
         end else if (stop_det) begin
            state  <= IDLE;
            SDA_IN <= 1'b1;
            BUSY   <= 1'b0;
         end else if (scl_rise) begin
            case (state)
               ADDR, PTR, WDATA: begin
                  sh      <= {sh[6:0], sda_s2};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               RDATA: bit_cnt <= bit_cnt + 1'b1;
               RDATA_ACK: begin
                  // Advance the pointer at the ACK sample so RD_DATA is settled for the reload on SCL fall
                  ack_bit <= sda_s2;
                  if (byte_cnt == LAST_BYTE) reg_addr <= reg_addr + 1'b1;
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state)
               ADDR: if (bit_cnt == 4'd8) begin
                  if (sh[7:1] == I2C_ADDR) begin
                     rnw    <= sh[0];
                     state  <= ADDR_ACK;
                     SDA_IN <= 1'b0;
                     BUSY   <= 1'b1;
                  end else begin
                     state <= IGNORE;
                     BUSY  <= 1'b0;
                  end
               end
               ADDR_ACK: begin
                  bit_cnt  <= '0;
                  byte_cnt <= '0;
                  if (rnw) begin
                     state  <= RDATA;
                     tx     <= RD_DATA;
                     SDA_IN <= RD_DATA[DW-1];
                  end else begin
                     state  <= PTR;
                     SDA_IN <= 1'b1;
                  end
               end
               PTR: if (bit_cnt == 4'd8) begin
                  reg_addr <= sh[REG_AW-1:0];
                  state    <= PTR_ACK;
                  SDA_IN   <= 1'b0;
               end
               PTR_ACK: begin
                  state    <= WDATA;
                  SDA_IN   <= 1'b1;
                  bit_cnt  <= '0;
                  byte_cnt <= '0;
               end
               WDATA: if (bit_cnt == 4'd8) begin
                  word   <= (word << 8) | DW'(sh);
                  state  <= WDATA_ACK;
                  SDA_IN <= 1'b0;
               end
               WDATA_ACK: begin
                  state   <= WDATA;
                  SDA_IN  <= 1'b1;
                  bit_cnt <= '0;
                  if (byte_cnt == LAST_BYTE) begin
                     WR_STB   <= 1'b1;
                     WR_DATA  <= word;
                     byte_cnt <= '0;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
               RDATA: begin
                  tx <= tx << 1;
                  if (bit_cnt == 4'd8) begin
                     state   <= RDATA_ACK;
                     SDA_IN  <= 1'b1;
                     bit_cnt <= '0;
                  end else begin
                     SDA_IN <= tx[DW-2];
                  end
               end
               RDATA_ACK: begin
                  if (ack_bit) begin
                     state  <= IGNORE;
                     SDA_IN <= 1'b1;
                     BUSY   <= 1'b0;
                  end else if (byte_cnt == LAST_BYTE) begin
                     state    <= RDATA;
                     byte_cnt <= '0;
                     tx       <= RD_DATA;
                     SDA_IN   <= RD_DATA[DW-1];
                  end else begin
                     state    <= RDATA;
                     byte_cnt <= byte_cnt + 1'b1;
                     SDA_IN   <= tx[DW-1];
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_burst.sv
// Directed bench for i2c_target_burst: write bursts, address mismatch, repeated-START reads,
// abort, async reset and (under I2C_TARGET_TIMEOUT_EN) SCL-low recovery.
module tb_i2c_target_burst;
   localparam int unsigned Q = 5;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        SCL = 1'b1;
   logic        SDA_OUT = 1'b1;
   logic        SDA_OE = 1'b0;
   logic [6:0]  I2C_ADDR = 7'h3D;
   logic [15:0] RD_DATA;
   logic        SDA_IN;
   logic [4:0]  reg_addr;
   logic        WR_STB;
   logic [15:0] WR_DATA;
   logic        BUSY;

   logic [15:0] rd_mem [0:31];
   logic [20:0] wr_q [$];
   logic [7:0]  rd_q [$];
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned stb_cnt = 0;
   logic        sda_low_seen = 1'b0;

   assign RD_DATA = rd_mem[reg_addr];

   i2c_target_burst #(.DATA_BYTES(2), .REG_AW(5), .TIMEOUT_CYC(64)) dut (
      .CLK(CLK), .RESET(RESET), .SCL(SCL), .SDA_OUT(SDA_OUT), .SDA_OE(SDA_OE),
      .I2C_ADDR(I2C_ADDR), .RD_DATA(RD_DATA), .SDA_IN(SDA_IN), .reg_addr(reg_addr),
      .WR_STB(WR_STB), .WR_DATA(WR_DATA), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (SDA_IN === 1'b0) sda_low_seen = 1'b1;
      if (WR_STB === 1'b1) begin
         logic [20:0] e;
         stb_cnt++;
         if (wr_q.size() == 0) begin
            check("wr_unexpected", 32'd1, 32'd0);
         end else begin
            e = wr_q.pop_front();
            check("wr_addr", 32'(reg_addr), 32'(e[20:16]));
            check("wr_data", 32'(WR_DATA), 32'(e[15:0]));
         end
      end
   end

   task automatic wait_clk(input int unsigned n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic i2c_start();
      SDA_OE = 1'b1; SDA_OUT = 1'b1; wait_clk(Q);
      SCL = 1'b1; wait_clk(Q);
      SDA_OUT = 1'b0; wait_clk(Q);
      SCL = 1'b0; wait_clk(Q);
   endtask

   task automatic i2c_stop();
      SDA_OE = 1'b1; SDA_OUT = 1'b0; wait_clk(Q);
      SCL = 1'b1; wait_clk(Q);
      SDA_OUT = 1'b1; wait_clk(Q);
   endtask

   task automatic bit_cycle(input logic drive, input logic b, output logic sampled);
      SDA_OE = drive; SDA_OUT = b; wait_clk(Q);
      SCL = 1'b1; wait_clk(Q);
      sampled = SDA_IN; wait_clk(Q);
      SCL = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_cycle(1'b1, b[i], s);
      bit_cycle(1'b0, 1'b1, ack);
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_cycle(1'b0, 1'b1, s);
         d[i] = s;
      end
      bit_cycle(1'b1, ack, s);
   endtask

   task automatic wr_expect_ack(input string tag, input logic [7:0] b, input logic exp_ack);
      logic a;
      write_byte(b, a);
      check(tag, 32'(a), 32'(exp_ack));
   endtask

   task automatic rd_check(input logic ack);
      logic [7:0] d;
      logic [7:0] e;
      read_byte(ack, d);
      if (rd_q.size() == 0) begin
         check("rd_unexpected", 32'd1, 32'd0);
      end else begin
         e = rd_q.pop_front();
         check("rd_byte", 32'(d), 32'(e));
      end
   endtask

   initial begin
      logic s;
      int unsigned stb_before;
      for (int i = 0; i < 32; i++) rd_mem[i] = 16'h0000;
      rd_mem[31] = 16'h07E8;
      rd_mem[0]  = 16'h1234;

      wait_clk(4);
      check("rst_sda", 32'(SDA_IN), 32'd1);
      check("rst_addr", 32'(reg_addr), 32'd0);
      check("rst_stb", 32'(WR_STB), 32'd0);
      check("rst_wdata", 32'(WR_DATA), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      RESET = 1'b1;
      wait_clk(4);

      // Write burst: two words starting at pointer 3
      i2c_start();
      wr_expect_ack("wb_addr_ack", 8'h7A, 1'b0);
      check("wb_busy", 32'(BUSY), 32'd1);
      wr_expect_ack("wb_ptr_ack", 8'h03, 1'b0);
      wr_q.push_back({5'd3, 16'h07CC});
      wr_q.push_back({5'd4, 16'h5BA7});
      wr_expect_ack("wb_d0_ack", 8'h07, 1'b0);
      wr_expect_ack("wb_d1_ack", 8'hCC, 1'b0);
      wr_expect_ack("wb_d2_ack", 8'h5B, 1'b0);
      wr_expect_ack("wb_d3_ack", 8'hA7, 1'b0);
      i2c_stop();
      wait_clk(8);
      check("wb_final_addr", 32'(reg_addr), 32'd5);
      check("wb_stb_cnt", 32'(stb_cnt), 32'd2);
      check("wb_q_empty", 32'(wr_q.size()), 32'd0);
      check("wb_busy_end", 32'(BUSY), 32'd0);

      // Address mismatch: nothing acknowledged, no strobe
      sda_low_seen = 1'b0;
      stb_before = stb_cnt;
      i2c_start();
      wr_expect_ack("mm_addr_nack", 8'h02, 1'b1);
      check("mm_busy", 32'(BUSY), 32'd0);
      wr_expect_ack("mm_d0_nack", 8'h07, 1'b1);
      wr_expect_ack("mm_d1_nack", 8'hCC, 1'b1);
      i2c_stop();
      wait_clk(8);
      check("mm_sda_low", 32'(sda_low_seen), 32'd0);
      check("mm_stb", 32'(stb_cnt), 32'(stb_before));
      check("mm_busy_end", 32'(BUSY), 32'd0);

      // Read with repeated START, pointer wraps 0x1F -> 0x00 -> 0x01
      i2c_start();
      wr_expect_ack("rd_waddr_ack", 8'h7A, 1'b0);
      wr_expect_ack("rd_ptr_ack", 8'h1F, 1'b0);
      check("rd_ptr", 32'(reg_addr), 32'h1F);
      i2c_start();
      wr_expect_ack("rd_raddr_ack", 8'h7B, 1'b0);
      rd_q.push_back(8'h07); rd_q.push_back(8'hE8);
      rd_q.push_back(8'h12); rd_q.push_back(8'h34);
      rd_check(1'b0);
      rd_check(1'b0);
      check("rd_wrap", 32'(reg_addr), 32'd0);
      rd_check(1'b0);
      rd_check(1'b1);
      check("rd_final_addr", 32'(reg_addr), 32'd1);
      check("rd_busy_nack", 32'(BUSY), 32'd0);
      check("rd_sda_nack", 32'(SDA_IN), 32'd1);
      i2c_stop();
      wait_clk(8);

      // Abort after one byte, then a full word proves the partial byte was dropped
      stb_before = stb_cnt;
      i2c_start();
      wr_expect_ack("ab_addr_ack", 8'h7A, 1'b0);
      wr_expect_ack("ab_ptr_ack", 8'h08, 1'b0);
      wr_expect_ack("ab_d0_ack", 8'h55, 1'b0);
      i2c_stop();
      wait_clk(8);
      check("ab_stb", 32'(stb_cnt), 32'(stb_before));
      check("ab_busy", 32'(BUSY), 32'd0);
      check("ab_sda", 32'(SDA_IN), 32'd1);
      check("ab_addr", 32'(reg_addr), 32'd8);
      wr_q.push_back({5'd8, 16'hABCD});
      i2c_start();
      wr_expect_ack("ab2_addr_ack", 8'h7A, 1'b0);
      wr_expect_ack("ab2_ptr_ack", 8'h08, 1'b0);
      wr_expect_ack("ab2_d0_ack", 8'hAB, 1'b0);
      wr_expect_ack("ab2_d1_ack", 8'hCD, 1'b0);
      i2c_stop();
      wait_clk(8);
      check("ab2_stb", 32'(stb_cnt), 32'(stb_before + 1));
      check("ab2_addr", 32'(reg_addr), 32'd9);

      // SCL held low mid-byte
      stb_before = stb_cnt;
      i2c_start();
      wr_expect_ack("to_addr_ack", 8'h7A, 1'b0);
      wr_expect_ack("to_ptr_ack", 8'h10, 1'b0);
      for (int i = 0; i < 3; i++) bit_cycle(1'b1, 1'b1, s);
      wait_clk(70 - Q);
`ifdef I2C_TARGET_TIMEOUT_EN
      check("to_busy", 32'(BUSY), 32'd0);
`else
      check("to_busy", 32'(BUSY), 32'd1);
`endif
      check("to_sda", 32'(SDA_IN), 32'd1);
      i2c_stop();
      wait_clk(8);
      check("to_stb", 32'(stb_cnt), 32'(stb_before));

      // Async reset while the target pulls SDA low on a read bit
      i2c_start();
      wr_expect_ack("rs_waddr_ack", 8'h7A, 1'b0);
      wr_expect_ack("rs_ptr_ack", 8'h1F, 1'b0);
      i2c_start();
      wr_expect_ack("rs_raddr_ack", 8'h7B, 1'b0);
      check("rs_pre_sda", 32'(SDA_IN), 32'd0);
      RESET = 1'b0;
      #1;
      check("rs_sda", 32'(SDA_IN), 32'd1);
      check("rs_addr", 32'(reg_addr), 32'd0);
      check("rs_busy", 32'(BUSY), 32'd0);
      check("rs_stb", 32'(WR_STB), 32'd0);
      wait_clk(4);
      SDA_OE = 1'b0; SCL = 1'b1;
      wait_clk(4);
      RESET = 1'b1;
      wait_clk(8);
      check("rs_q_empty", 32'(wr_q.size() + rd_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
